// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler producing HI/LO write data.
// Accepts one MULT/MULTU/DIV/DIVU request, stalls execute while the op is
// in flight, and emits a single registered hilo_wen pulse with the result.
// Optional build macro: MD_EARLY_OUT_EN (divides with |divisor| > |dividend|
// complete in one cycle).
module md_sched #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_start,
  input  logic [1:0]  e_op,
  input  logic [31:0] e_srca,
  input  logic [31:0] e_srcb,
  input  logic        flush,
  output logic        e_stall,
  output logic        busy,
  output logic        hilo_wen,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [1:0]       op;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      dvsr;

  logic        start_signed;
  logic [31:0] start_mag_a;
  logic [31:0] start_mag_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [32:0] trial;
  logic [31:0] diff;
  logic        take;
  logic [31:0] rem_next;
  logic        div_signed;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Operand magnitudes at acceptance; only DIV treats its operands as signed.
  always_comb begin
    start_signed = (e_op == 2'd2);
    start_mag_a  = (start_signed & e_srca[31]) ? -e_srca : e_srca;
    start_mag_b  = (start_signed & e_srcb[31]) ? -e_srcb : e_srcb;
  end

`ifdef MD_EARLY_OUT_EN
  logic early_out;

  // A nonzero divisor larger than the dividend gives quotient 0, remainder = dividend.
  always_comb begin
    early_out = (start_mag_b != 32'd0) && (start_mag_b > start_mag_a);
  end
`endif

  // Full 64-bit product; MULT sign-extends the latched operands, MULTU zero-extends.
  always_comb begin
    ext_a   = {{32{~op[0] & op_a[31]}}, op_a};
    ext_b   = {{32{~op[0] & op_b[31]}}, op_b};
    product = ext_a * ext_b;
  end

  // One restoring-division step: shift in the next dividend bit and try a subtract.
  always_comb begin
    trial    = {rem, quo[31]};
    take     = (trial >= {1'b0, dvsr});
    diff     = trial[31:0] - dvsr;
    rem_next = take ? diff : trial[31:0];
  end

  // Sign fix-up of the magnitude result; divide by zero returns all-ones / raw dividend.
  always_comb begin
    div_signed = (op == 2'd2);
    if (op_b == 32'd0) begin
      fix_lo = 32'hFFFF_FFFF;
      fix_hi = op_a;
    end else begin
      fix_lo = (div_signed & (op_a[31] ^ op_b[31])) ? -quo : quo;
      fix_hi = (div_signed & op_a[31]) ? -rem : rem;
    end
  end

  // Sequencer: accepts an op, runs multiply or divide, then pulses hilo_wen once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      op       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      hilo_wen <= 1'b0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      hilo_wen <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        counter <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (e_start) begin
              op      <= e_op;
              op_a    <= e_srca;
              op_b    <= e_srcb;
              counter <= '0;
              rem     <= '0;
              quo     <= start_mag_a;
              dvsr    <= start_mag_b;
              if (!e_op[1]) begin
                state <= S_MUL;
              end
`ifdef MD_EARLY_OUT_EN
              else if (early_out) begin
                state    <= S_DONE;
                hilo_wen <= 1'b1;
                hi_wdata <= e_srca;
                lo_wdata <= '0;
              end
`endif
              else begin
                state <= S_DIV;
              end
            end
          end
          S_MUL: begin
            if (counter == MUL_LAST) begin
              state    <= S_DONE;
              counter  <= '0;
              hilo_wen <= 1'b1;
              hi_wdata <= product[63:32];
              lo_wdata <= product[31:0];
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
          S_DIV: begin
            rem <= rem_next;
            quo <= {quo[30:0], take};
            if (counter == DIV_LAST) begin
              state   <= S_FIX;
              counter <= '0;
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
          S_FIX: begin
            state    <= S_DONE;
            hilo_wen <= 1'b1;
            hi_wdata <= fix_hi;
            lo_wdata <= fix_lo;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy    = (state != S_IDLE);
  assign e_stall = ~rst & (((state == S_IDLE) & e_start & ~flush) |
                           (state == S_MUL) | (state == S_DIV) | (state == S_FIX));

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed plus randomized checks of md_sched against an
// arithmetic reference model (64-bit products, truncating signed division).
module tb_md_sched;

  localparam int MUL_CYCLES = 3;
  localparam int DIV_ITERS  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_start;
  logic [1:0]  e_op;
  logic [31:0] e_srca;
  logic [31:0] e_srcb;
  logic        flush;
  logic        e_stall;
  logic        busy;
  logic        hilo_wen;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int checks = 0;
  int passes = 0;

  md_sched #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(DIV_ITERS)) dut (
    .clk      (clk),
    .rst      (rst),
    .e_start  (e_start),
    .e_op     (e_op),
    .e_srca   (e_srca),
    .e_srcb   (e_srcb),
    .flush    (flush),
    .e_stall  (e_stall),
    .busy     (busy),
    .hilo_wen (hilo_wen),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: products and quotients from plain 64-bit arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    if (op == 2'd0 || op == 2'd2) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    if (op[1] == 1'b0) begin
      p   = sa * sb;
      hi  = p[63:32];
      lo  = p[31:0];
      lat = MUL_CYCLES + 1;
    end else begin
      lat = DIV_ITERS + 2;
      if (b == 32'd0) begin
        lo = 32'hFFFF_FFFF;
        hi = a;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
`ifdef MD_EARLY_OUT_EN
        if ((sb < 0 ? -sb : sb) > (sa < 0 ? -sa : sa)) lat = 1;
`endif
      end
    end
  endfunction

  // Runs one complete operation and checks timing, stall, result and hold.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    int lat;
    int k;
    int stallBad;
    refModel(op, a, b, eh, el, lat);
    @(negedge clk);
    e_start = 1'b1;
    e_op    = op;
    e_srca  = a;
    e_srcb  = b;
    flush   = 1'b0;
    #1;
    checkOutput({tag, " stall@T"}, {31'd0, e_stall}, 32'd1);
    @(negedge clk);
    e_start  = 1'b0;
    e_srca   = $urandom;
    e_srcb   = $urandom;
    k        = 1;
    stallBad = 0;
    while (hilo_wen !== 1'b1 && k < 80) begin
      if (e_stall !== 1'b1) stallBad++;
      @(negedge clk);
      e_srca = $urandom;
      e_srcb = $urandom;
      k++;
    end
    checkOutput({tag, " latency"}, k, lat);
    checkOutput({tag, " stall-in-flight"}, stallBad, 32'd0);
    checkOutput({tag, " hi"}, hi_wdata, eh);
    checkOutput({tag, " lo"}, lo_wdata, el);
    checkOutput({tag, " stall@done"}, {31'd0, e_stall}, 32'd0);
    @(negedge clk);
    checkOutput({tag, " wen-pulse"}, {31'd0, hilo_wen}, 32'd0);
    checkOutput({tag, " busy-after"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " hi-held"}, hi_wdata, eh);
    checkOutput({tag, " lo-held"}, lo_wdata, el);
  endtask

  initial begin
    int strayWen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int sel;

    rst     = 1'b1;
    e_start = 1'b1;
    e_op    = 2'd0;
    e_srca  = 32'd0;
    e_srcb  = 32'd0;
    flush   = 1'b0;
    #12;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset wen", {31'd0, hilo_wen}, 32'd0);
    checkOutput("reset hi", hi_wdata, 32'd0);
    checkOutput("reset lo", lo_wdata, 32'd0);
    checkOutput("reset stall", {31'd0, e_stall}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    e_start = 1'b0;

    $display("[TB] directed multiply/divide cases");
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, "MULT -1*2");
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, "MULTU");
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, "DIV -7/2");
    applyStimulus(2'd3, 32'd100, 32'd7, "DIVU 100/7");
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow");
    applyStimulus(2'd3, 32'd5, 32'd0, "DIVU by zero");
    applyStimulus(2'd2, 32'hFFFF_FFF0, 32'd0, "DIV by zero neg");
    applyStimulus(2'd3, 32'd3, 32'd10, "DIVU 3/10");

    $display("[TB] flush mid-divide");
    @(negedge clk);
    e_start = 1'b1;
    e_op    = 2'd3;
    e_srca  = 32'd1000;
    e_srcb  = 32'd3;
    @(negedge clk);
    e_start  = 1'b0;
    strayWen = 0;
    for (int i = 1; i < 10; i++) begin
      if (hilo_wen !== 1'b0) strayWen++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy@T+11", {31'd0, busy}, 32'd0);
    checkOutput("flush no-wen", strayWen + int'(hilo_wen), 32'd0);
    applyStimulus(2'd1, 32'd3, 32'd4, "MULTU after flush");
    strayWen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_wen !== 1'b0) strayWen++;
    end
    checkOutput("flushed div never writes", strayWen, 32'd0);

    $display("[TB] flush with start in idle");
    @(negedge clk);
    e_start = 1'b1;
    flush   = 1'b1;
    e_op    = 2'd1;
    e_srca  = 32'd9;
    e_srcb  = 32'd9;
    #1;
    checkOutput("flush+start stall", {31'd0, e_stall}, 32'd0);
    @(negedge clk);
    e_start = 1'b0;
    flush   = 1'b0;
    checkOutput("flush+start busy", {31'd0, busy}, 32'd0);
    strayWen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hilo_wen !== 1'b0) strayWen++;
    end
    checkOutput("flush+start no-wen", strayWen, 32'd0);

    $display("[TB] reset mid-divide");
    @(negedge clk);
    e_start = 1'b1;
    e_op    = 2'd2;
    e_srca  = 32'h1234_5678;
    e_srcb  = 32'd17;
    @(negedge clk);
    e_start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst     = 1'b1;
    e_start = 1'b1;
    #1;
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset wen", {31'd0, hilo_wen}, 32'd0);
    checkOutput("midreset hi", hi_wdata, 32'd0);
    checkOutput("midreset lo", lo_wdata, 32'd0);
    checkOutput("midreset stall", {31'd0, e_stall}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    e_start = 1'b0;
    strayWen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_wen !== 1'b0) strayWen++;
    end
    checkOutput("midreset no-wen", strayWen, 32'd0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        rb = 32'd0;
      end else if (sel == 1) begin
        ra = $urandom_range(0, 50);
        rb = $urandom_range(1, 60);
      end else if (sel == 2) begin
        rb = $urandom_range(1, 15);
      end else if (sel == 3) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      applyStimulus(rop, ra, rb, "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Scheduler and sequencer for the multiply/divide resource that produces HI/LO write data.
- Accepts one MULT/MULTU/DIV/DIVU request from the execute stage.
- Holds the pipeline stalled while the operation is in flight.
- Issues a single registered HI/LO write pulse toward writeback/hazard logic.
- Aborts cleanly on pipeline flush (exception/eret).

Parameters:
- MUL_CYCLES, 3, fixed multiply latency in cycles (≥1) from accepted start to hilo_wen.
- DIV_ITERS, 32, radix-2 iteration count; must equal operand width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- e_start  in  1  execute stage presents a mult/div op this cycle
- e_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- e_srca  in  32  rs operand (dividend / multiplicand)
- e_srcb  in  32  rt operand (divisor / multiplier)
- flush  in  1  pipeline flush; kills any in-flight op
- e_stall  out  1  hold execute and earlier stages
- busy  out  1  state != IDLE
- hilo_wen  out  1  one-cycle pulse: write hi_wdata/lo_wdata
- hi_wdata  out  32  HI result (product[63:32] / remainder)
- lo_wdata  out  32  LO result (product[31:0] / quotient)

Behaviour:
- Reset: state=IDLE, counter=0, busy=0, hilo_wen=0, hi_wdata=0, lo_wdata=0. Combinational e_stall=0 while in reset.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: e_start & ~flush → latch op and operands, counter=0.
  - MULT/MULTU → MUL.
  - DIV/DIVU → DIV; DIV captures operand magnitudes and both sign bits.
  - e_start while not IDLE is ignored; stall prevents it legally.
- MUL: 64-bit product of latched operands, signed for MULT, zero-extended for MULTU. Counter increments each cycle; at counter==MUL_CYCLES-1 → DONE. MUL_CYCLES=1 passes through one MUL cycle.
- DIV: restoring radix-2 on unsigned magnitudes, one quotient bit per cycle, MSB first. After DIV_ITERS cycles → FIX.
- FIX: sign correction, one cycle.
  - Quotient negated if sign(a)^sign(b) and op==DIV.
  - Remainder takes the dividend's sign (op==DIV).
  - Quotient truncates toward zero. Then → DONE.
- Divide by zero: run the full sequence.
  - Result: lo=32'hFFFFFFFF, hi=dividend (raw e_srca), for both DIV and DIVU.
  - No exception is raised.
- Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0.
- DONE: hilo_wen=1 for exactly one cycle, hi/lo_wdata valid that cycle and held afterward. → IDLE.
- Latency from the accepting cycle T:
  - multiply: hilo_wen at T+MUL_CYCLES+1.
  - divide: hilo_wen at T+DIV_ITERS+2 (34 by default).
- e_stall = (state==IDLE & e_start & ~flush) | (state∈{MUL,DIV,FIX}). e_stall is 0 in DONE, so the dependent mfhi/mflo after the op uses the writeback bypass.
- busy = (state != IDLE).
- flush in any state: next state IDLE, counter cleared, hilo_wen=0 next cycle, hi/lo_wdata unchanged.
  - flush has priority over the DONE transition: flush in the DONE cycle still lets that cycle's hilo_wen=1 stand. This matches the commit point, because the op is already retired.
- flush together with e_start in IDLE: the op is not accepted and e_stall=0.
- Reset mid-operation: immediate return to reset values, no write.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: in IDLE, for DIV/DIVU where |divisor| > |dividend| (unsigned magnitudes, divisor≠0), go directly to DONE with lo=0, hi=dividend (raw). hilo_wen is at T+1 and e_stall is high only in cycle T.
- Not defined: all divides take the full DIV_ITERS+2 latency, and the comparator logic is absent.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 → hilo_wen at T+4, hi=0xFFFFFFFF, lo=0xFFFFFFFE; e_stall high T..T+3. Repeat as MULTU → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → hilo_wen at T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- Start DIVU, assert flush at T+10 → no hilo_wen ever; busy=0 from T+11. A new MULTU 3*4 at T+12 → hi=0, lo=12 at T+16.
- flush and e_start asserted together in IDLE → e_stall=0, state stays IDLE. Async rst pulse mid-divide → all outputs 0 immediately.
- With MD_EARLY_OUT_EN: DIVU a=3, b=10 → hilo_wen at T+1, lo=0, hi=3. Without the macro → same values at T+34.
